// File: rtl/game_pkg.sv
// Shared types and width helpers for the game-flow controller and its per-player slices.
package game_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        DONE  = 2'd2
    } game_state_t;

    // Bits needed to hold a heart count of 0..max_hearts.
    function automatic int hw_width(input int max_hearts);
        return $clog2(max_hearts + 1);
    endfunction

    // Bits needed for a player index; never narrower than one bit.
    function automatic int pw_width(input int num_players);
        return (num_players <= 2) ? 1 : $clog2(num_players);
    endfunction

    // Bits for the invulnerability countdown; a zero cooldown still gets one bit.
    function automatic int cd_width(input int hit_cooldown);
        return (hit_cooldown < 1) ? 1 : $clog2(hit_cooldown + 1);
    endfunction

endpackage

// File: rtl/player_life.sv
// One tank's life state: saturating heart counter plus post-hit invulnerability countdown.
module player_life
    import game_pkg::*;
#(
    parameter int MAX_HEARTS   = 5,
    parameter int START_HEARTS = 4,
    parameter int HIT_COOLDOWN = 30,
    localparam int HW = hw_width(MAX_HEARTS),
    localparam int CW = cd_width(HIT_COOLDOWN)
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          hit_req,
    input  logic          grab,
    input  logic          enable,
    output logic [HW-1:0] hearts,
    output logic          alive,
    output logic          invuln,
    output logic          alive_nxt
);

    logic [HW-1:0] hearts_q, hearts_d;
    logic [CW-1:0] cooldown_q, cooldown_d;
    logic          hit;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        hearts_d   = hearts_q;
        cooldown_d = cooldown_q;
        hit        = 1'b0;
        if (start) begin
            hearts_d   = HW'(START_HEARTS);
            cooldown_d = '0;
        end else if (enable && (hearts_q != '0)) begin
            hit = hit_req && (cooldown_q == '0);
            // A hit and a grab together cancel; grabs stop at the ceiling.
            if (grab && !hit && (hearts_q != HW'(MAX_HEARTS))) begin
                hearts_d = hearts_q + 1'b1;
            end else if (hit && !grab) begin
                hearts_d = hearts_q - 1'b1;
            end
            if (hit) begin
                cooldown_d = CW'(HIT_COOLDOWN);
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (Reset) begin
            hearts_q   <= '0;
            cooldown_q <= '0;
        end else begin
            hearts_q   <= hearts_d;
            cooldown_q <= cooldown_d;
        end
    end

    assign hearts    = hearts_q;
    assign alive     = (hearts_q != '0);
    assign invuln    = (cooldown_q != '0);
    assign alive_nxt = (hearts_d != '0);

endmodule

// File: rtl/game_ctrl_n.sv
// Frame-rate game-flow controller for N tanks: hearts, cooldowns, heart power-up, winner/draw.
module game_ctrl_n
    import game_pkg::*;
#(
    parameter int         NUM_PLAYERS  = 2,
    parameter int         MAX_HEARTS   = 5,
    parameter int         START_HEARTS = 4,
    parameter int         HIT_COOLDOWN = 30,
    parameter int         SPAWN_THRESH = 5,
    parameter logic [7:0] RESTART_KEY  = 8'h0A,
    localparam int HW = hw_width(MAX_HEARTS),
    localparam int PW = pw_width(NUM_PLAYERS)
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [NUM_PLAYERS-1:0]    shot_hit,
    input  logic [NUM_PLAYERS-1:0]    powerup_grab,
    input  logic [31:0]               keycode,
    output logic [NUM_PLAYERS*HW-1:0] hearts,
    output logic [NUM_PLAYERS-1:0]    alive,
    output logic [NUM_PLAYERS-1:0]    invuln,
    output logic                      heart_showup,
    output logic                      game_over,
    output logic [PW-1:0]             winner,
    output logic                      draw
);

    localparam int SW = $clog2(NUM_PLAYERS * MAX_HEARTS + 1);
    localparam int AW = $clog2(NUM_PLAYERS + 1);

    game_state_t             state_q, state_d;
    logic                    showup_q, showup_d;
    logic [PW-1:0]           winner_q, winner_d;
    logic                    draw_q, draw_d;

    logic [NUM_PLAYERS-1:0]  alive_nxt;
    logic [NUM_PLAYERS-1:0]  grab_cand;
    logic [NUM_PLAYERS-1:0]  grab_oh;
    logic                    grab_any;
    logic [SW-1:0]           heart_sum;
    logic [AW-1:0]           alive_cnt;
    logic [PW-1:0]           last_alive;
    logic                    start_en;
    logic                    play_en;
    logic                    unused_key;

    assign start_en   = (state_q == START);
    assign play_en    = (state_q == PLAY);
    assign unused_key = ^keycode[31:8];

    // Only living players can touch the heart; lowest index wins via isolate-lowest-set-bit.
    assign grab_cand = powerup_grab & alive & {NUM_PLAYERS{showup_q}};
    assign grab_oh   = grab_cand & (~grab_cand + 1'b1);
    assign grab_any  = |grab_cand;

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        player_life #(
            .MAX_HEARTS   (MAX_HEARTS),
            .START_HEARTS (START_HEARTS),
            .HIT_COOLDOWN (HIT_COOLDOWN)
        ) u_life (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .start     (start_en),
            .hit_req   (shot_hit[i]),
            .grab      (grab_oh[i]),
            .enable    (play_en),
            .hearts    (hearts[i*HW +: HW]),
            .alive     (alive[i]),
            .invuln    (invuln[i]),
            .alive_nxt (alive_nxt[i])
        );
    end

    // Dead players hold zero hearts, so summing every slot equals the alive-player total.
    always_comb begin
        heart_sum = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            heart_sum = heart_sum + SW'(hearts[i*HW +: HW]);
        end
    end

    always_comb begin
        alive_cnt  = '0;
        last_alive = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_nxt[i]) begin
                alive_cnt  = alive_cnt + 1'b1;
                last_alive = PW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        showup_d = showup_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        case (state_q)
            START: begin
                showup_d = 1'b0;
                winner_d = '0;
                draw_d   = 1'b0;
                state_d  = PLAY;
            end
            PLAY: begin
                // Clearing and spawning are exclusive in one cycle, so a grab never re-spawns at once.
                if (showup_q) begin
                    showup_d = !grab_any;
                end else begin
                    showup_d = (int'(heart_sum) <= SPAWN_THRESH);
                end
                if (alive_cnt == AW'(1)) begin
                    winner_d = last_alive;
                    draw_d   = 1'b0;
                    showup_d = 1'b0;
                    state_d  = DONE;
                end else if (alive_cnt == '0) begin
                    draw_d   = 1'b1;
                    showup_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                showup_d = 1'b0;
                if (keycode[7:0] == RESTART_KEY) begin
                    state_d = START;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= START;
            showup_q <= 1'b0;
            winner_q <= '0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            showup_q <= showup_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
        end
    end

    assign heart_showup = showup_q;
    assign game_over    = (state_q == DONE);
    assign winner       = winner_q;
    assign draw         = draw_q;

endmodule

// File: tb/tb_game_ctrl_n.sv
// Directed plus randomized checks of game_ctrl_n (4 players, 3-frame cooldown) against a rule-level model.
module tb_game_ctrl_n;

    localparam int N    = 4;
    localparam int MAXH = 5;
    localparam int STH  = 4;
    localparam int HC   = 3;
    localparam int THR  = 5;
    localparam int HW   = 3;
    localparam int PW   = 2;

    logic              frame_clk = 1'b0;
    logic              Reset;
    logic [N-1:0]      shot_hit;
    logic [N-1:0]      powerup_grab;
    logic [31:0]       keycode;
    logic [N*HW-1:0]   hearts;
    logic [N-1:0]      alive;
    logic [N-1:0]      invuln;
    logic              heart_showup;
    logic              game_over;
    logic [PW-1:0]     winner;
    logic              draw;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = waiting to load, 1 = playing, 2 = finished.
    int m_h[N];
    int m_cd[N];
    int m_phase;
    bit m_show;
    int m_win;
    bit m_draw;

    game_ctrl_n #(
        .NUM_PLAYERS  (N),
        .MAX_HEARTS   (MAXH),
        .START_HEARTS (STH),
        .HIT_COOLDOWN (HC),
        .SPAWN_THRESH (THR),
        .RESTART_KEY  (8'h0A)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .shot_hit     (shot_hit),
        .powerup_grab (powerup_grab),
        .keycode      (keycode),
        .hearts       (hearts),
        .alive        (alive),
        .invuln       (invuln),
        .heart_showup (heart_showup),
        .game_over    (game_over),
        .winner       (winner),
        .draw         (draw)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_h[i]  = 0;
            m_cd[i] = 0;
        end
        m_phase = 0;
        m_show  = 1'b0;
        m_win   = 0;
        m_draw  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] sh, input logic [N-1:0] gr, input logic [7:0] key);
        int  taker;
        int  sum;
        int  survivors;
        int  last;
        int  delta;
        bit  hit;
        if (m_phase == 0) begin
            for (int i = 0; i < N; i++) begin
                m_h[i]  = STH;
                m_cd[i] = 0;
            end
            m_show  = 1'b0;
            m_win   = 0;
            m_draw  = 1'b0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            taker = -1;
            sum   = 0;
            for (int i = 0; i < N; i++) begin
                sum += m_h[i];
                if (m_show && taker < 0 && gr[i] && m_h[i] > 0) taker = i;
            end
            survivors = 0;
            last      = 0;
            for (int i = 0; i < N; i++) begin
                if (m_h[i] > 0) begin
                    hit   = sh[i] && (m_cd[i] == 0);
                    delta = ((i == taker) ? 1 : 0) - (hit ? 1 : 0);
                    m_h[i] = m_h[i] + delta;
                    if (m_h[i] > MAXH) m_h[i] = MAXH;
                    if (m_h[i] < 0) m_h[i] = 0;
                    if (hit) m_cd[i] = HC;
                    else if (m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
                end
                if (m_h[i] > 0) begin
                    survivors++;
                    last = i;
                end
            end
            if (m_show) m_show = (taker < 0);
            else        m_show = (sum <= THR);
            if (survivors == 1) begin
                m_win   = last;
                m_draw  = 1'b0;
                m_show  = 1'b0;
                m_phase = 2;
            end else if (survivors == 0) begin
                m_draw  = 1'b1;
                m_show  = 1'b0;
                m_phase = 2;
            end
        end else begin
            m_show = 1'b0;
            if (key == 8'h0A) m_phase = 0;
        end
    endtask

    function automatic logic [N*HW-1:0] exp_hearts();
        logic [N*HW-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) e[i*HW +: HW] = HW'(m_h[i]);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_alive();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = (m_h[i] > 0);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_invuln();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = (m_cd[i] > 0);
        return e;
    endfunction

    task automatic cmp_all();
        check("hearts", 64'(hearts), 64'(exp_hearts()));
        check("alive", 64'(alive), 64'(exp_alive()));
        check("invuln", 64'(invuln), 64'(exp_invuln()));
        check("heart_showup", 64'(heart_showup), 64'(m_show));
        check("game_over", 64'(game_over), 64'(m_phase == 2));
        check("draw", 64'(draw), 64'(m_draw));
        if (m_phase == 2 && !m_draw) check("winner", 64'(winner), 64'(m_win));
    endtask

    task automatic step(input logic [N-1:0] sh, input logic [N-1:0] gr, input logic [7:0] key);
        shot_hit     = sh;
        powerup_grab = gr;
        keycode      = {24'($urandom), key};
        @(posedge frame_clk);
        model_step(sh, gr, key);
        #1;
        cmp_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hearts"}, 64'(hearts), 64'd0);
        check({tag, "_alive"}, 64'(alive), 64'd0);
        check({tag, "_invuln"}, 64'(invuln), 64'd0);
        check({tag, "_showup"}, 64'(heart_showup), 64'd0);
        check({tag, "_game_over"}, 64'(game_over), 64'd0);
        check({tag, "_winner"}, 64'(winner), 64'd0);
        check({tag, "_draw"}, 64'(draw), 64'd0);
    endtask

    initial begin
        int seq[10] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1};
        logic [N-1:0] rsh;
        logic [N-1:0] rgr;
        logic [7:0]   rkey;

        Reset        = 1'b1;
        shot_hit     = '0;
        powerup_grab = '0;
        keycode      = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge frame_clk);
        Reset = 1'b0;

        step('0, '0, 8'h00);
        step('0, '0, 8'h00);
        check("start_hearts", 64'(hearts), 64'h924);
        check("start_alive", 64'(alive), 64'hF);
        check("start_game_over", 64'(game_over), 64'd0);
        check("start_showup", 64'(heart_showup), 64'd0);

        // Held hit on player 0: one heart lost every HC+1 frames.
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, '0, 8'h00);
            check($sformatf("cooldown_seq_%0d", k), 64'(hearts[2:0]), 64'(seq[k]));
        end
        for (int k = 0; k < 3; k++) step('0, '0, 8'h00);

        // Kill players 2 and 3; the pool drops to 1+4 = 5.
        for (int k = 0; k < 13; k++) step(4'b1100, '0, 8'h00);
        check("after_kill_hearts", 64'(hearts), 64'h021);
        step('0, '0, 8'h00);
        check("spawn_at_thresh", 64'(heart_showup), 64'd1);

        step('0, 4'b0011, 8'h00);
        check("grab_priority_hearts", 64'(hearts), 64'h022);
        check("grab_clears_showup", 64'(heart_showup), 64'd0);
        step('0, '0, 8'h00);
        check("no_spawn_above_thresh", 64'(heart_showup), 64'd0);

        // Hit and grab on the same frame cancel out.
        step(4'b0001, '0, 8'h00);
        step(4'b0100, '0, 8'h00);
        check("respawn_showup", 64'(heart_showup), 64'd1);
        step('0, '0, 8'h00);
        step('0, '0, 8'h00);
        step(4'b0001, 4'b0001, 8'h00);
        check("hit_grab_hearts0", 64'(hearts[2:0]), 64'd1);
        check("hit_grab_showup", 64'(heart_showup), 64'd0);
        check("hit_grab_invuln0", 64'(invuln[0]), 64'd1);
        step('0, '0, 8'h00);
        check("respawn_next_frame", 64'(heart_showup), 64'd1);

        for (int k = 0; k < 30 && m_phase != 2; k++) step(4'b0010, '0, 8'h00);
        check("win_game_over", 64'(game_over), 64'd1);
        check("win_winner", 64'(winner), 64'd0);
        check("win_draw", 64'(draw), 64'd0);

        for (int k = 0; k < 3; k++) step(4'hF, 4'hF, 8'h00);
        check("done_hold_hearts", 64'(hearts), 64'h001);
        check("done_showup", 64'(heart_showup), 64'd0);

        step('0, '0, 8'h0A);
        check("restart_start", 64'(game_over), 64'd0);
        step('0, '0, 8'h00);
        check("restart_hearts", 64'(hearts), 64'h924);
        check("restart_alive", 64'(alive), 64'hF);

        // Everybody down to one heart, then a simultaneous final volley.
        for (int k = 0; k < 12; k++) step(4'hF, '0, 8'h00);
        check("all_one_heart", 64'(hearts), 64'h249);
        step(4'hF, '0, 8'h00);
        check("draw_flag", 64'(draw), 64'd1);
        check("draw_game_over", 64'(game_over), 64'd1);
        check("draw_alive", 64'(alive), 64'd0);

        step('0, '0, 8'h0A);
        step('0, '0, 8'h00);

        for (int k = 0; k < 400; k++) begin
            rsh  = N'($urandom) & N'($urandom);
            rgr  = N'($urandom);
            rkey = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            step(rsh, rgr, rkey);
        end

        // Asynchronous reset between edges, in the middle of a game.
        step('0, '0, 8'h0A);
        step('0, '0, 8'h00);
        step(4'b0001, '0, 8'h00);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
        #1;
        check("post_reset_hearts_zero", 64'(hearts), 64'd0);
        step('0, '0, 8'h00);
        check("post_reset_load", 64'(hearts), 64'h924);
        check("post_reset_game_over", 64'(game_over), 64'd0);
        step('0, '0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
